// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared control-bundle field positions, bubble value and ID/EX sequencer states
package cpu_ctrl_pkg;
  localparam int CTRL_ALUOP_LSB = 6;
  localparam int CTRL_ALUSRC = 5;
  localparam int CTRL_REGWRITE = 4;
  localparam int CTRL_MEMTOREG = 3;
  localparam int CTRL_MEMREAD = 2;
  localparam int CTRL_MEMWRITE = 1;
  localparam logic [7:0] CTRL_BUBBLE = '0;
  typedef enum logic {PASS, BUBBLE} bub_state_t;
endpackage

// File: rtl/bubble_seq.sv
// bubble_seq: load-use bubble sequencer deciding when ID/EX loads a bubble and IF/ID must hold
module bubble_seq
  import cpu_ctrl_pkg::*;
#(
  parameter int BUBBLES = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic hazard_i,
  input  logic flush_i,
  input  logic stall_i,
  output logic insert_bubble,
  output logic hold_o
);
  bub_state_t state, state_n;
  logic [3:0] remaining, remaining_n;
  logic busy;
  assign busy = (state == BUBBLE) || hazard_i;
  assign insert_bubble = !flush_i && !stall_i && busy;
  assign hold_o = !rst_i && !flush_i && busy;
  always_comb begin
    state_n = state;
    remaining_n = remaining;
    if (flush_i) begin
      state_n = PASS;
      remaining_n = '0;
    end else if (!stall_i && state == BUBBLE) begin
      state_n = (remaining == 4'd1) ? PASS : BUBBLE;
      remaining_n = remaining - 4'd1;
    end else if (!stall_i && hazard_i) begin
      state_n = (BUBBLES == 1) ? PASS : BUBBLE;
      remaining_n = 4'(BUBBLES - 1);
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= PASS;
      remaining <= '0;
    end else begin
      state <= state_n;
      remaining <= remaining_n;
    end
  end
endmodule

// File: rtl/id_ex_ctrl_stage.sv
// id_ex_ctrl_stage: ID/EX control/rd pipeline register with hazard bubbles, flush, stall and bubble stats
module id_ex_ctrl_stage
  import cpu_ctrl_pkg::*;
#(
  parameter int CTRL_W = 8,
  parameter int REG_ADDR_W = 5,
  parameter int BUBBLES = 1,
  parameter int CNT_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [CTRL_W-1:0]     ctrl_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic                  valid_i,
  input  logic                  hazard_i,
  input  logic                  flush_i,
  input  logic                  stall_i,
  output logic [CTRL_W-1:0]     ctrl_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic                  valid_o,
  output logic                  hold_o,
  output logic [CNT_W-1:0]      bubble_cnt_o
);
  logic insert_bubble;
  bubble_seq #(.BUBBLES(BUBBLES)) u_seq (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .hazard_i(hazard_i),
    .flush_i(flush_i),
    .stall_i(stall_i),
    .insert_bubble(insert_bubble),
    .hold_o(hold_o)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i || (!stall_i && insert_bubble)) begin
      ctrl_o <= CTRL_W'(CTRL_BUBBLE);
      rd_o <= '0;
      valid_o <= 1'b0;
    end else if (!stall_i) begin
      ctrl_o <= valid_i ? ctrl_i : '0;
      rd_o <= valid_i ? rd_i : '0;
      valid_o <= valid_i;
    end
  end
  // flush bubbles are squashes, not hazard bubbles, so insert_bubble already excludes them
  always_ff @(posedge clk_i) begin
    if (rst_i) bubble_cnt_o <= '0;
    else if (insert_bubble && bubble_cnt_o != '1) bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
  end
endmodule

// File: doc/id_ex_ctrl_stage.md
Name: id_ex_ctrl_stage

Overview:
- Parametrised ID/EX pipeline register for the decoded control bundle and destination register.
- Inserts hazard bubbles, holding them for a configurable load-use penalty, and back-pressures IF/ID through hold_o.
- Squashes on branch flush and freezes on downstream stall.
- Keeps a saturating count of inserted bubbles for performance debug.

Parameters:
- CTRL_W, 8, width of packed control bundle {ALUOp[1:0], ALUSrc, RegWrite, MemToReg, MemRead, MemWrite, spare}.
- REG_ADDR_W, 5, destination register address width.
- BUBBLES, 1, bubbles inserted per hazard_i event; legal range 1..15.
- CNT_W, 16, width of the bubble statistics counter.

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, synchronous active-high reset.
- ctrl_i, in, CTRL_W, decoded control bundle from ID.
- rd_i, in, REG_ADDR_W, destination register from ID.
- valid_i, in, 1, ID holds a real instruction.
- hazard_i, in, 1, load-use hazard detected this cycle.
- flush_i, in, 1, squash the instruction entering EX (taken branch/jump).
- stall_i, in, 1, downstream hold; the register keeps its contents.
- ctrl_o, out, CTRL_W, registered control bundle to EX.
- rd_o, out, REG_ADDR_W, registered destination register.
- valid_o, out, 1, EX holds a real instruction.
- hold_o, out, 1, freeze PC and IF/ID this cycle.
- bubble_cnt_o, out, CNT_W, saturating count of bubbles inserted.

Behaviour:
- Reset: clock and reset are as stated under Ports. On rst_i, ctrl_o=0, rd_o=0, valid_o=0, bubble_cnt_o=0, state=PASS, remaining=0, hold_o=0.
- Bubble value: ctrl_o=0, rd_o=0 (x0), valid_o=0. A bubble writes no register and performs no memory access.
- Latency: 1 cycle from ID inputs to outputs when passing.
- States: PASS and BUBBLE. A 4-bit `remaining` counter is active only in BUBBLE.
- Per-edge priority: rst_i > flush_i > stall_i > bubble insertion > normal load.
- flush_i: load a bubble, set state=PASS and remaining=0. Overrides stall_i and any hazard in progress. A flush bubble does not increment bubble_cnt_o.
- stall_i (no flush): all outputs, state and remaining hold. bubble_cnt_o holds.
- PASS, hazard_i=1, no stall/flush:
  - Load a bubble and increment bubble_cnt_o.
  - If BUBBLES==1, stay in PASS.
  - Otherwise go to BUBBLE with remaining=BUBBLES-1.
- BUBBLE, no stall/flush:
  - Load a bubble and increment bubble_cnt_o; remaining decrements.
  - When remaining reaches 1 before decrement, go to PASS.
  - hazard_i is ignored in BUBBLE; the counter is never reloaded.
- PASS, hazard_i=0, no stall/flush: load ctrl_i, rd_i, valid_i. When valid_i=0, ctrl_o and rd_o are forced to 0.
- hold_o (combinational): (state==BUBBLE) | (state==PASS & hazard_i). Forced to 0 while flush_i=1 or rst_i=1. It is independent of stall_i, which the hazard unit ORs externally.
- bubble_cnt_o saturates at all-ones and never wraps.
- hazard_i and stall_i in the same cycle: stall wins. Upstream still holds via hold_o, so hazard_i is re-sampled next cycle.
- rst_i during BUBBLE: immediately PASS, remaining=0, hold_o=0 in the reset cycle.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - field LSB constants CTRL_ALUOP_LSB=6, CTRL_ALUSRC=5, CTRL_REGWRITE=4, CTRL_MEMTOREG=3, CTRL_MEMREAD=2, CTRL_MEMWRITE=1;
  - CTRL_BUBBLE = '0;
  - the state enum {PASS, BUBBLE}.
- One sub-module, bubble_seq: the FSM plus the remaining counter. It produces insert_bubble and hold_o. The top level holds the datapath register and the statistics counter.

Test Plan:
- Reset, then ctrl_i=8'hB8, rd_i=5'd7, valid_i=1 -> next cycle ctrl_o=8'hB8, rd_o=7, valid_o=1, hold_o=0.
- BUBBLES=1, single-cycle hazard_i pulse -> hold_o=1 that cycle; next cycle ctrl_o=0, rd_o=0, valid_o=0; bubble_cnt_o=1; following cycle the held instruction passes.
- BUBBLES=3, hazard_i held high 3 cycles -> hold_o=1 for 3 cycles, 3 consecutive bubbles, bubble_cnt_o=3, state PASS afterwards.
- BUBBLES=3, flush_i on 2nd bubble cycle -> bubble loaded, hold_o=0 that cycle, state PASS, bubble_cnt_o=1.
- stall_i with hazard_i in the same cycle -> outputs unchanged, bubble_cnt_o unchanged; bubble inserted the cycle stall_i drops.
- CNT_W=4, 20 hazard events with BUBBLES=1 -> bubble_cnt_o saturates at 4'hF; rst_i mid-BUBBLE clears to 0 and PASS.
